keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Scans a 4x4 matrix keypad by driving one column low at a time and reading the rows.
//  Debounces press and release, then presents a 16-bit one-hot key code for the keypad encoder.
//  One-hot output holds until the next accepted key; the encoder takes it unchanged on clk.
//  Also counts accepted presses (tries) for the display / game logic.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles per scan tick; must be >= 4 so rows settle after a column change
//  DEB_TICKS  10     consecutive matching ticks needed to accept a press or a release (>= 1)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  row        in   4   keypad rows, active-low, asynchronous to clk
//  cnt_clr    in   1   synchronous clear of key_cnt
//  col        out  4   column drive, active-low; exactly one bit low at all times
//  onehot     out  16  accepted key code, bit = col_idx*4 + row_idx; 0 until first key
//  key_valid  out  1   1-cycle strobe in the cycle onehot updates
//  key_down   out  1   high from acceptance until release is accepted
//  key_cnt    out  8   accepted presses, saturates at 255
// BEHAVIOUR
//  Reset (async, immediate):
//   col=4'b1110 (col_idx 0), onehot=0, key_valid=0, key_down=0, key_cnt=0
//   state=SCAN, tick counter=0, deb_cnt=0, row synchroniser=4'hF
//  Row input: 2-FF synchroniser -> row_s. All row decisions are made only on tick.
//  Tick: counter runs 0..SCAN_DIV-1 and wraps; tick=1 when counter==SCAN_DIV-1.
//  Valid row: row_s has exactly one 0 bit. row_idx = index of that bit (row[0] -> 0).
//  States (all transitions on tick only):
//   SCAN: valid row -> latch row_lat=row_s, deb_cnt=0, go to DEB, col held.
//         Otherwise (all-high or multi-low) col_idx=col_idx+1 (3 wraps to 0).
//   DEB:  row_s==row_lat -> deb_cnt++.
//         On the DEB_TICKS-th matching tick -> go to HOLD and, in that same cycle:
//           onehot<=1<<{col_idx,row_idx}, key_valid=1, key_down=1, key_cnt++.
//         row_s!=row_lat -> go to SCAN and advance col_idx; no strobe.
//   HOLD: row_s==4'hF -> go to REL, deb_cnt=0. Otherwise stay (held key or extra keys ignored).
//   REL:  row_s==4'hF -> deb_cnt++. On the DEB_TICKS-th tick -> go to SCAN, key_down=0, advance col_idx.
//         row_s!=4'hF -> go back to HOLD; no new strobe.
//  col holds its value in DEB, HOLD and REL.
//  key_cnt: cnt_clr has priority, so a same-cycle cnt_clr and accept gives 0. Holds at 255.
//  onehot changes only on accept; it is never cleared except by rst.
//  Reset mid-debounce or mid-hold returns everything to the reset values above. No pending strobe survives.
// STRUCTURE
//  Shared package keypad_pkg:
//   constants NCOL=4, NROW=4, COL_RST=4'b1110, ROW_IDLE=4'hF
//   2-bit state encodings SCAN=0, DEB=1, HOLD=2, REL=3
//  One sub-module: key_sync (2-FF synchroniser, width param, async reset to all-ones) for row.
//  Tick counter, FSM, deb_cnt and key_cnt stay in keypad_scan_ctrl.
// TESTING (SCAN_DIV=4, DEB_TICKS=3; keypad model pulls row[r] low while col[c] is low and key (c,r) is pressed)
//  1 Reset, no keys:
//     col=1110, onehot=0, key_cnt=0; col=1101 after 4 clk; back to 1110 after 16 clk.
//     Assert rst mid-tick: col=1110 in the same cycle.
//  2 Hold key (0,3):
//     onehot=16'h0008 and one key_valid pulse on the 3rd tick after detection; key_cnt=1, key_down=1, col stays 1110.
//  3 Bounce: row[1] low for 1 tick on col 1, then high:
//     no key_valid, onehot unchanged, col advances to 1011.
//  4 Keys (1,0) and (1,2) together:
//     multi-low is ignored, scan continues, no strobe.
//     Then hold (2,1) only: onehot=16'h0200.
//  5 Release (2,1) with a 1-tick re-press glitch in REL:
//     returns to HOLD, no 2nd strobe; key_down falls 3 clean ticks after final release.
//  6 cnt_clr in the key_valid cycle -> key_cnt=0.
//     Then 256 presses -> key_cnt=255 (saturated).
//     rst asserted in DEB -> no strobe.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, state encoding and row helpers for the keypad scanner
package keypad_pkg;

  localparam int NCOL = 4;
  localparam int NROW = 4;
  localparam logic [3:0] COL_RST  = 4'b1110;
  localparam logic [3:0] ROW_IDLE = 4'hF;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    DEB  = 2'd1,
    HOLD = 2'd2,
    REL  = 2'd3
  } state_t;

  // A row pattern is usable only when exactly one line is pulled low.
  function automatic logic one_low(input logic [3:0] r);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 4; i++) begin
      if (!r[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - 2-FF synchroniser for asynchronous inputs, resets to all-ones
module key_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with press/release debounce and one-hot key code
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        cnt_clr,
  output logic [3:0]  col,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_down,
  output logic [7:0]  key_cnt
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEB_TICKS + 1);
  localparam int CIDX_W = $clog2(NCOL);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);

  logic [NROW-1:0]   row_s;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [CIDX_W-1:0] col_idx;
  logic [3:0]        row_lat;
  logic [DEB_W-1:0]  deb_cnt;
  state_t            state, state_nxt;

  logic row_valid, row_match, row_idle, deb_last;
  logic accept, released, latch_row, deb_clr, deb_inc, step_col;

  key_sync #(.WIDTH(NROW)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + DIV_W'(1);
  end

  assign tick      = (div_cnt == DIV_LAST);
  assign row_valid = one_low(row_s);
  assign row_match = (row_s == row_lat);
  assign row_idle  = (row_s == ROW_IDLE);
  assign deb_last  = (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SCAN;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        SCAN: if (row_valid) state_nxt = DEB;
        DEB:  if (!row_match) state_nxt = SCAN;
              else if (deb_last) state_nxt = HOLD;
        HOLD: if (row_idle) state_nxt = REL;
        REL:  if (!row_idle) state_nxt = HOLD;
              else if (deb_last) state_nxt = SCAN;
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_comb begin
    accept    = 1'b0;
    released  = 1'b0;
    latch_row = 1'b0;
    deb_clr   = 1'b0;
    deb_inc   = 1'b0;
    step_col  = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          latch_row = row_valid;
          deb_clr   = row_valid;
          step_col  = !row_valid;
        end
        DEB: begin
          deb_inc  = row_match;
          accept   = row_match && deb_last;
          step_col = !row_match;
        end
        HOLD: deb_clr = row_idle;
        REL: begin
          deb_inc  = row_idle;
          released = row_idle && deb_last;
          step_col = row_idle && deb_last;
        end
        default: ;
      endcase
    end
  end

  // Column index and debounce bookkeeping; col is decoded straight from col_idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_idx <= '0;
      row_lat <= ROW_IDLE;
      deb_cnt <= '0;
    end else begin
      if (step_col) col_idx <= col_idx + CIDX_W'(1);
      if (latch_row) row_lat <= row_s;
      if (deb_clr) deb_cnt <= '0;
      else if (deb_inc) deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign col = ~(4'(1) << col_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onehot    <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      key_cnt   <= '0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        onehot   <= 16'(1) << {col_idx, low_idx(row_lat)};
        key_down <= 1'b1;
      end else if (released) begin
        key_down <= 1'b0;
      end
      if (cnt_clr) key_cnt <= '0;
      else if (accept && key_cnt != 8'hFF) key_cnt <= key_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed bench with a behavioural keypad scanner model
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_TICKS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cnt_clr = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_down;
  logic [7:0]  key_cnt;
  logic [15:0] keys = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int kv_seen = 0;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .cnt_clr   (cnt_clr),
    .col       (col),
    .onehot    (onehot),
    .key_valid (key_valid),
    .key_down  (key_down),
    .key_cnt   (key_cnt)
  );

  always #5 clk = ~clk;

  // Key (c,r) pressed shorts column c to row r.
  function automatic logic [3:0] row_of(input logic [3:0] c, input logic [15:0] k);
    logic [3:0] r;
    r = 4'hF;
    for (int ci = 0; ci < 4; ci++)
      for (int ri = 0; ri < 4; ri++)
        if (!c[ci] && k[ci*4+ri]) r[ri] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] col_of(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  always_comb row = row_of(col, keys);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 scanning, 1 confirming a press, 2 key held, 3 confirming release.
  int          m_col = 0, m_mode = 0, m_dc = 0, m_div = 0, m_cnt = 0;
  logic [3:0]  m_s1 = 4'hF, m_s2 = 4'hF, m_lat = 4'hF;
  logic [15:0] m_onehot = '0;
  logic        m_kv = 1'b0, m_kd = 1'b0;

  initial begin
    logic [3:0] rs;
    int zeros, ridx;
    bit tk, acc;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_col = 0; m_mode = 0; m_dc = 0; m_div = 0; m_cnt = 0;
        m_s1 = 4'hF; m_s2 = 4'hF; m_onehot = '0; m_kv = 1'b0; m_kd = 1'b0;
      end else begin
        rs = m_s2;
        m_s2 = m_s1;
        m_s1 = row_of(col_of(m_col), keys);
        tk = (m_div == SCAN_DIV - 1);
        m_div = (m_div + 1) % SCAN_DIV;
        m_kv = 1'b0;
        acc = 1'b0;
        if (tk) begin
          zeros = 0; ridx = 0;
          for (int i = 0; i < 4; i++) if (!rs[i]) begin zeros++; ridx = i; end
          if (m_mode == 0) begin
            if (zeros == 1) begin m_lat = rs; m_dc = 0; m_mode = 1; end
            else m_col = (m_col + 1) % 4;
          end else if (m_mode == 1) begin
            if (rs == m_lat) begin
              m_dc++;
              if (m_dc == DEB_TICKS) begin
                m_mode = 2; acc = 1'b1; m_kv = 1'b1; m_kd = 1'b1;
                for (int i = 0; i < 4; i++) if (!m_lat[i]) ridx = i;
                m_onehot = 16'h0001 << (m_col * 4 + ridx);
              end
            end else begin
              m_mode = 0; m_col = (m_col + 1) % 4;
            end
          end else if (m_mode == 2) begin
            if (rs == 4'hF) begin m_mode = 3; m_dc = 0; end
          end else begin
            if (rs == 4'hF) begin
              m_dc++;
              if (m_dc == DEB_TICKS) begin m_mode = 0; m_kd = 1'b0; m_col = (m_col + 1) % 4; end
            end else m_mode = 2;
          end
        end
        if (cnt_clr) m_cnt = 0;
        else if (acc && m_cnt < 255) m_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("col", 32'(col), 32'(col_of(m_col)));
        check("onehot", 32'(onehot), 32'(m_onehot));
        check("key_valid", 32'(key_valid), 32'(m_kv));
        check("key_down", 32'(key_down), 32'(m_kd));
        check("key_cnt", 32'(key_cnt), 32'(m_cnt));
        if (key_valid) kv_seen++;
      end
    end
  end

  task automatic wait_kv();
    for (int k = 0; k < 200 && !key_valid; k++) begin @(posedge clk); #1; end
    check("kv_wait", 32'(key_valid), 32'd1);
  endtask

  task automatic wait_kd_low();
    for (int k = 0; k < 200 && key_down; k++) begin @(posedge clk); #1; end
    check("kd_fall_wait", 32'(key_down), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_col", 32'(col), 32'h0000000E);
    check("rst_onehot", 32'(onehot), 32'h0);
    check("rst_cnt", 32'(key_cnt), 32'h0);

    // 1: free scan, then reset in the middle of a tick period
    repeat (4) @(posedge clk); #1;
    check("scan_col1", 32'(col), 32'h0000000D);
    repeat (12) @(posedge clk); #1;
    check("scan_wrap", 32'(col), 32'h0000000E);
    repeat (4) @(posedge clk); #2;
    rst = 1'b1; #1;
    check("async_rst_col", 32'(col), 32'h0000000E);
    @(negedge clk); rst = 1'b0;

    // 2: hold key (0,3)
    keys = 16'h0008;
    repeat (16) @(posedge clk); #1;
    check("k03_valid", 32'(key_valid), 32'd1);
    check("k03_onehot", 32'(onehot), 32'h0008);
    check("k03_cnt", 32'(key_cnt), 32'd1);
    check("k03_down", 32'(key_down), 32'd1);
    check("k03_col", 32'(col), 32'h0000000E);
    @(posedge clk); #1;
    check("k03_pulse", 32'(key_valid), 32'd0);
    keys = '0;
    wait_kd_low();
    check("k03_col_next", 32'(col), 32'h0000000D);

    // 3: one-tick bounce on (1,1)
    keys = 16'h0020;
    repeat (4) @(posedge clk); #1;
    keys = '0;
    repeat (4) @(posedge clk); #1;
    check("bounce_col", 32'(col), 32'h0000000B);
    check("bounce_onehot", 32'(onehot), 32'h0008);
    check("bounce_cnt", 32'(key_cnt), 32'd1);

    // 4: two keys on one column are ignored, then (2,1)
    keys = 16'h0050;
    repeat (32) @(posedge clk); #1;
    check("multi_no_strobe", 32'(kv_seen), 32'd1);
    keys = 16'h0200;
    wait_kv();
    check("k21_onehot", 32'(onehot), 32'h0200);
    check("k21_cnt", 32'(key_cnt), 32'd2);

    // 5: release with a one-tick re-press glitch
    keys = '0;
    repeat (8) @(posedge clk); #1;
    keys = 16'h0200;
    repeat (4) @(posedge clk); #1;
    keys = '0;
    repeat (15) @(posedge clk); #1;
    check("rel_still_down", 32'(key_down), 32'd1);
    @(posedge clk); #1;
    check("rel_down_fall", 32'(key_down), 32'd0);
    check("rel_no_strobe", 32'(kv_seen), 32'd2);

    // 6: clear on accept, saturation, reset during debounce
    cnt_clr = 1'b1;
    keys = 16'h4000;
    wait_kv();
    check("clr_cnt", 32'(key_cnt), 32'd0);
    check("k32_onehot", 32'(onehot), 32'h4000);
    cnt_clr = 1'b0;
    keys = '0;
    wait_kd_low();
    for (int i = 0; i < 256; i++) begin
      keys = 16'h0001;
      wait_kv();
      keys = '0;
      wait_kd_low();
    end
    check("sat_cnt", 32'(key_cnt), 32'd255);
    check("sat_strobes", 32'(kv_seen), 32'd259);

    keys = 16'h1111;
    repeat (6) @(posedge clk); #2;
    rst = 1'b1; #1;
    check("deb_rst_valid", 32'(key_valid), 32'd0);
    check("deb_rst_onehot", 32'(onehot), 32'h0);
    check("deb_rst_cnt", 32'(key_cnt), 32'd0);
    keys = '0;
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk); #1;
    check("deb_rst_no_strobe", 32'(kv_seen), 32'd259);
    check("deb_rst_down", 32'(key_down), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
